// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, feeds the instruction memory and
// registers the fetched word into IF/ID, resolving redirects in fixed priority.
module if_fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        exc_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        irq_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic [31:0] epc_o,
    output logic        kernel_o
);

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_plus4;
    logic        bubble;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        bubble = 1'b1;
        if (branch_taken_i) begin
            pc_d = {pc_q[31], branch_target_i[30:0]};
        end else if (exc_i) begin
            pc_d  = EXC_VEC;
            epc_d = pc4_q;
        end else if (stall_i) begin
            bubble = 1'b0;
        end else if (jr_i) begin
            pc_d = jr_target_i;
        end else if (jump_i) begin
            pc_d = {pc_q[31], jump_target_i[30:0]};
        end else if (irq_i && !pc_q[31]) begin
            pc_d  = IRQ_VEC;
            epc_d = pc_q;
        end else begin
            pc_d   = pc_plus4;
            bubble = 1'b0;
        end
    end

    // A stall holds IF/ID; every other non-sequential event squashes it.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP;
            pc4_d   = pc_plus4;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = instr_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            instr_q <= NOP;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            epc_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
        end
    end

    assign pc_o             = pc_q;
    assign if_id_instr_o    = instr_q;
    assign if_id_pc_plus4_o = pc4_q;
    assign if_id_valid_o    = valid_q;
    assign epc_o            = epc_q;
    assign kernel_o         = pc_q[31];

endmodule
